// File: rtl/gbc_gamepak_pkg.sv
// Shared types and constants for the GamePak bus sequencer.
package gbc_gamepak_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } gp_state_e;

  // Default cartridge RAM window (inclusive).
  localparam logic [15:0] GBC_CS_LO_DEFAULT = 16'hA000;
  localparam logic [15:0] GBC_CS_HI_DEFAULT = 16'hFDFF;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gbc_gamepak_sync2.sv
// Two-flop level synchroniser with synchronous active-low reset (clears to 0).
module gbc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gbc_gamepak_sequencer.sv
// GamePak bus sequencer: phases single-beat requests into setup/strobe/hold pin cycles.
// Optional cartridge audio capture is enabled with `define GBC_GAMEPAK_AUDIO_EN.
module gbc_gamepak_sequencer
  import gbc_gamepak_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SETUP_CLKS  = 2,
  parameter int unsigned STROBE_CLKS = 4,
  parameter int unsigned HOLD_CLKS   = 1,
  parameter logic [ADDR_WIDTH-1:0] CS_LO = ADDR_WIDTH'(GBC_CS_LO_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] CS_HI = ADDR_WIDTH'(GBC_CS_HI_DEFAULT)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqData,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  PakClk,
  output logic                  PakRead,
  output logic                  PakWrite,
  output logic                  PakCS,
  output logic [ADDR_WIDTH-1:0] PakAddress,
  output logic [DATA_WIDTH-1:0] PakDOut,
  output logic                  PakDOE,
  input  logic [DATA_WIDTH-1:0] PakDIn,
  output logic                  PakReset,
  input  logic                  PakAudio,
  output logic                  AudioSample
);

  localparam int unsigned CNT_MAX = max3(SETUP_CLKS, STROBE_CLKS, HOLD_CLKS);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  gp_state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  pak_clk_q, pak_clk_d;
  logic                  pak_read_q, pak_read_d;
  logic                  pak_write_q, pak_write_d;
  logic                  pak_cs_q, pak_cs_d;
  logic                  pak_doe_q, pak_doe_d;
  logic [DATA_WIDTH-1:0] pak_dout_q, pak_dout_d;
  logic                  pak_reset_q;

  logic expire;
  logic strobe_done;
  logic active_d;
  logic strobe_d;
  logic in_window_d;

  assign expire      = (cnt_q == CNT_W'(1));
  assign strobe_done = (state_q == STROBE) && expire;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, phase counter and request latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (ReqValid && req_ready_q) begin
          addr_d  = ReqAddr;
          data_d  = ReqData;
          wr_d    = ReqWrite;
          cnt_d   = CNT_W'(SETUP_CLKS);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (expire) begin
          cnt_d   = CNT_W'(STROBE_CLKS);
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (expire) begin
          cnt_d   = CNT_W'(HOLD_CLKS);
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (expire) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs are decoded from the next state so they register in step with it
  always_comb begin
    active_d    = (state_d != IDLE);
    strobe_d    = (state_d == STROBE);
    in_window_d = (addr_d >= CS_LO) && (addr_d <= CS_HI);

    req_ready_d = !active_d;
    pak_clk_d   = strobe_d;
    pak_read_d  = strobe_d && !wr_d;
    pak_write_d = strobe_d && wr_d;
    pak_cs_d    = active_d && in_window_d;
    pak_doe_d   = active_d && wr_d;
    pak_dout_d  = (active_d && wr_d) ? data_d : '0;
    rsp_valid_d = strobe_done && !wr_q;
    rsp_data_d  = (strobe_done && !wr_q) ? PakDIn : rsp_data_q;
  end

  // Datapath and output registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      pak_clk_q   <= 1'b0;
      pak_read_q  <= 1'b0;
      pak_write_q <= 1'b0;
      pak_cs_q    <= 1'b0;
      pak_doe_q   <= 1'b0;
      pak_dout_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      pak_clk_q   <= pak_clk_d;
      pak_read_q  <= pak_read_d;
      pak_write_q <= pak_write_d;
      pak_cs_q    <= pak_cs_d;
      pak_doe_q   <= pak_doe_d;
      pak_dout_q  <= pak_dout_d;
    end
  end

  // Cartridge reset follows the system reset one cycle later
  always_ff @(posedge Clk) begin
    pak_reset_q <= ~Reset;
  end

  assign ReqReady   = req_ready_q;
  assign RspValid   = rsp_valid_q;
  assign RspData    = rsp_data_q;
  assign PakClk     = pak_clk_q;
  assign PakRead    = pak_read_q;
  assign PakWrite   = pak_write_q;
  assign PakCS      = pak_cs_q;
  assign PakAddress = addr_q;
  assign PakDOut    = pak_dout_q;
  assign PakDOE     = pak_doe_q;
  assign PakReset   = pak_reset_q;

`ifdef GBC_GAMEPAK_AUDIO_EN
  gbc_sync2 u_audio_sync (
    .clk   (Clk),
    .rst_n (Reset),
    .d     (PakAudio),
    .q     (AudioSample)
  );
`else
  logic unused_pak_audio;
  assign unused_pak_audio = PakAudio;
  assign AudioSample      = 1'b0;
`endif

endmodule

// File: doc/gbc_gamepak_sequencer.md
# gbc_gamepak_sequencer

Parametrised GamePak bus sequencer that turns single-beat read/write requests from the CPU/DMA side into correctly phased cartridge-edge cycles (address setup, strobe, hold). It drives the cartridge pins: Clk, Read, Write, CS, Address, data and Reset. It sits between the system bus arbiter and the cartridge pins, replacing hard-wired pin assignment. Width, timing and chip-select window are generic, and there is optional cartridge-audio capture.

## Interface
Parameters:
- ADDR_WIDTH, 16, cartridge address width
- DATA_WIDTH, 8, cartridge data width
- SETUP_CLKS, 2, Clk cycles of address/CS setup before strobe (≥1)
- STROBE_CLKS, 4, Clk cycles Read/Write held asserted (≥1)
- HOLD_CLKS, 1, Clk cycles of address hold after strobe (≥1)
- CS_LO, 16'hA000, lowest address asserting PakCS
- CS_HI, 16'hFDFF, highest address asserting PakCS

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  sequencer can accept
- ReqWrite  in  1  1 = write, 0 = read
- ReqAddr  in  ADDR_WIDTH  request address
- ReqData  in  DATA_WIDTH  write data
- RspValid  out  1  one-cycle pulse, read data valid
- RspData  out  DATA_WIDTH  read data
- PakClk  out  1  cartridge clock
- PakRead  out  1  read strobe (active-high; pad inverts)
- PakWrite  out  1  write strobe (active-high; pad inverts)
- PakCS  out  1  RAM-window select (active-high)
- PakAddress  out  ADDR_WIDTH  cartridge address
- PakDOut  out  DATA_WIDTH  data to cartridge
- PakDOE  out  1  data-bus output enable
- PakDIn  in  DATA_WIDTH  data from cartridge
- PakReset  out  1  cartridge reset, active-high
- PakAudio  in  1  cartridge VIN audio (used only with audio enabled)
- AudioSample  out  1  synchronised VIN level

## Operation
- States: IDLE, SETUP, STROBE, HOLD. A single down-counter is sized for max(SETUP_CLKS, STROBE_CLKS, HOLD_CLKS).
- IDLE: ReqReady=1. On ReqValid&&ReqReady, latch addr/data/dir, load counter with SETUP_CLKS, and go to SETUP.
- SETUP: PakAddress is the latched address. PakCS=1 iff CS_LO≤addr≤CS_HI (unsigned compare). For a write, PakDOE=1 and PakDOut is the latched data. On counter expiry, load STROBE_CLKS and go to STROBE.
- STROBE: PakRead or PakWrite=1 and PakClk=1. On the final STROBE cycle, PakDIn is registered into RspData (read only). On expiry, load HOLD_CLKS and go to HOLD.
- HOLD: strobes and PakClk=0. Address, CS and DOE are held. RspValid=1 in the first HOLD cycle for reads only. On expiry, go to IDLE.
- ReqReady is 0 outside IDLE. No request queuing; the requester holds ReqValid until accepted.
- PakReset = ~Reset registered (one-cycle delayed).
- RspData holds its last value until the next read completes.

## Timing
- Reset (Reset=0 at an edge): next cycle state=IDLE, ReqReady=1, RspValid=0, RspData=0. PakClk, PakRead, PakWrite, PakCS, PakDOE and PakDOut are 0. PakAddress=0, PakReset=1, AudioSample=0.
- Reset mid-access aborts immediately. Strobes drop on the next edge and no RspValid is issued.
- Access occupancy is SETUP_CLKS+STROBE_CLKS+HOLD_CLKS cycles plus one IDLE cycle. With defaults: 8 cycles per access, 7-cycle acceptance-to-RspValid latency.
- Strobes never overlap address changes: the address is stable ≥SETUP_CLKS before and ≥HOLD_CLKS after the strobe.
- ReqValid asserted during a non-IDLE state is ignored. It is accepted on the first IDLE edge.
- Address window boundaries are inclusive. With CS_LO>CS_HI, PakCS never asserts.

## Configuration
- GBC_GAMEPAK_AUDIO_EN defined: PakAudio passes through a 2-flop synchroniser to AudioSample. Latency is 2 Clk cycles and the reset value is 0.
- Without GBC_GAMEPAK_AUDIO_EN: AudioSample is tied 0, PakAudio is unused, and no flops are inferred.

## Structure
- Package gbc_gamepak_pkg holds the state enum (IDLE/SETUP/STROBE/HOLD) and the default CS window constants.
- One sub-module, gbc_sync2 (2-flop synchroniser), is instantiated only under GBC_GAMEPAK_AUDIO_EN.

## Test plan
- Read 0x4000, PakDIn=0x5A: PakRead high cycles 3–6, PakCS=0, RspValid pulse in cycle 7 with RspData=0x5A, ReqReady back in cycle 8.
- Write 0xA123 data 0xC3: PakCS=1 and PakDOE=1 cycles 1–7, PakWrite high cycles 3–6, PakDOut=0xC3, no RspValid.
- CS boundaries: addresses 0x9FFF/0xA000/0xFDFF/0xFE00 → PakCS 0/1/1/0.
- Back-to-back requests with ReqValid held: second acceptance exactly 8 cycles after the first, and the address never changes while a strobe is high.
- Reset=0 during STROBE of a read: next cycle all strobes 0, PakReset=1, no RspValid; the post-reset request completes normally.
- Audio with GBC_GAMEPAK_AUDIO_EN: PakAudio 0→1 yields AudioSample=1 two cycles later. Without the macro, AudioSample stays 0.
